// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_txrx transceiver.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } uart_state_t;

endpackage

// File: rtl/uart_txrx_if.sv
// Byte-side handshake and serial pins of uart_txrx; i_Loopback exists only with UART_LOOPBACK_EN.
interface uart_txrx_if;
  import uart_pkg::*;

  logic                 i_TX_DV;
  logic [DATA_BITS-1:0] i_TX_Byte;
  logic                 o_TX_Active;
  logic                 o_TX_Serial;
  logic                 o_TX_Done;
  logic                 i_RX_Serial;
  logic                 o_RX_DV;
  logic [DATA_BITS-1:0] o_RX_Byte;
`ifdef UART_LOOPBACK_EN
  logic                 i_Loopback;

  modport master (
    output i_TX_DV, i_TX_Byte, i_RX_Serial, i_Loopback,
    input  o_TX_Active, o_TX_Serial, o_TX_Done, o_RX_DV, o_RX_Byte
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte, i_RX_Serial, i_Loopback,
    output o_TX_Active, o_TX_Serial, o_TX_Done, o_RX_DV, o_RX_Byte
  );
`else
  modport master (
    output i_TX_DV, i_TX_Byte, i_RX_Serial,
    input  o_TX_Active, o_TX_Serial, o_TX_Done, o_RX_DV, o_RX_Byte
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte, i_RX_Serial,
    output o_TX_Active, o_TX_Serial, o_TX_Done, o_RX_DV, o_RX_Byte
  );
`endif

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: o_Tick marks the last clock of a full bit (or of the half-bit
// start-bit wait when i_Half=1); wraps to zero on the tick.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Clear,
  input  logic i_En,
  input  logic i_Half,
  output logic o_Tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_TERM = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TERM = CW'((CLKS_PER_BIT - 1) / 2);

  logic [CW-1:0] r_Count;
  logic [CW-1:0] w_Term;

  assign w_Term = i_Half ? HALF_TERM : FULL_TERM;
  assign o_Tick = i_En && (r_Count == w_Term);

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n || i_Clear) begin
      r_Count <= '0;
    end else if (o_Tick) begin
      r_Count <= '0;
    end else if (i_En) begin
      r_Count <= r_Count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART (independent TX and RX FSMs sharing one baud divisor).
// Optional `UART_LOOPBACK_EN adds i_Loopback, routing the TX line into the RX synchronizer.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  uart_txrx_if.slave  io_Bus
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  // ---------------- Transmitter ----------------
  uart_state_t          r_TX_State, w_TX_Next;
  logic [DATA_BITS-1:0] r_TX_Data;
  logic [BIT_W-1:0]     r_TX_Bit;
  logic                 w_TX_Tick;
  logic                 w_TX_Serial, w_TX_Active, w_TX_Done;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Clear (r_TX_State == IDLE || r_TX_State == CLEANUP),
    .i_En    (w_TX_Active),
    .i_Half  (1'b0),
    .o_Tick  (w_TX_Tick)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) r_TX_State <= IDLE;
    else          r_TX_State <= w_TX_Next;
  end

  always_comb begin
    w_TX_Next = r_TX_State;
    case (r_TX_State)
      IDLE:    if (io_Bus.i_TX_DV) w_TX_Next = START;
      START:   if (w_TX_Tick) w_TX_Next = DATA;
      DATA:    if (w_TX_Tick && r_TX_Bit == LAST_BIT) w_TX_Next = STOP;
      STOP:    if (w_TX_Tick) w_TX_Next = CLEANUP;
      CLEANUP: w_TX_Next = IDLE;
      default: w_TX_Next = IDLE;
    endcase
  end

  always_comb begin
    w_TX_Serial = 1'b1;
    w_TX_Active = 1'b0;
    w_TX_Done   = 1'b0;
    case (r_TX_State)
      START: begin
        w_TX_Serial = 1'b0;
        w_TX_Active = 1'b1;
      end
      DATA: begin
        w_TX_Serial = r_TX_Data[r_TX_Bit];
        w_TX_Active = 1'b1;
      end
      STOP:    w_TX_Active = 1'b1;
      CLEANUP: w_TX_Done   = 1'b1;
      default: ;
    endcase
  end

  // Byte is captured only on acceptance, so requests mid-frame cannot disturb it.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_TX_Data <= '0;
      r_TX_Bit  <= '0;
    end else begin
      if (r_TX_State == IDLE && io_Bus.i_TX_DV) r_TX_Data <= io_Bus.i_TX_Byte;
      if (r_TX_State != DATA) r_TX_Bit <= '0;
      else if (w_TX_Tick)     r_TX_Bit <= r_TX_Bit + 1'b1;
    end
  end

  assign io_Bus.o_TX_Serial = w_TX_Serial;
  assign io_Bus.o_TX_Active = w_TX_Active;
  assign io_Bus.o_TX_Done   = w_TX_Done;

  // ---------------- Receiver ----------------
  uart_state_t          r_RX_State, w_RX_Next;
  logic                 r_RX_Sync1, r_RX_Sync2;
  logic [DATA_BITS-1:0] r_RX_Shift;
  logic [DATA_BITS-1:0] r_RX_Byte;
  logic [BIT_W-1:0]     r_RX_Bit;
  logic                 w_RX_Tick;
  logic                 w_RX_Pin;
  logic                 w_RX_DV;

`ifdef UART_LOOPBACK_EN
  assign w_RX_Pin = io_Bus.i_Loopback ? (w_TX_Active ? w_TX_Serial : 1'b1)
                                      : io_Bus.i_RX_Serial;
`else
  assign w_RX_Pin = io_Bus.i_RX_Serial;
`endif

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_RX_Sync1 <= 1'b1;
      r_RX_Sync2 <= 1'b1;
    end else begin
      r_RX_Sync1 <= w_RX_Pin;
      r_RX_Sync2 <= r_RX_Sync1;
    end
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Clear (r_RX_State == IDLE || r_RX_State == CLEANUP),
    .i_En    (r_RX_State == START || r_RX_State == DATA || r_RX_State == STOP),
    .i_Half  (r_RX_State == START),
    .o_Tick  (w_RX_Tick)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) r_RX_State <= IDLE;
    else          r_RX_State <= w_RX_Next;
  end

  always_comb begin
    w_RX_Next = r_RX_State;
    case (r_RX_State)
      IDLE:    if (!r_RX_Sync2) w_RX_Next = START;
      START:   if (w_RX_Tick) w_RX_Next = r_RX_Sync2 ? IDLE : DATA;
      DATA:    if (w_RX_Tick && r_RX_Bit == LAST_BIT) w_RX_Next = STOP;
      STOP:    if (w_RX_Tick) w_RX_Next = r_RX_Sync2 ? CLEANUP : IDLE;
      CLEANUP: w_RX_Next = IDLE;
      default: w_RX_Next = IDLE;
    endcase
  end

  always_comb begin
    w_RX_DV = 1'b0;
    if (r_RX_State == CLEANUP) w_RX_DV = 1'b1;
  end

  // Output byte moves only on a good stop bit, so framing errors leave it intact.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_RX_Shift <= '0;
      r_RX_Byte  <= '0;
      r_RX_Bit   <= '0;
    end else begin
      if (r_RX_State == DATA && w_RX_Tick) r_RX_Shift[r_RX_Bit] <= r_RX_Sync2;
      if (r_RX_State != DATA) r_RX_Bit <= '0;
      else if (w_RX_Tick)     r_RX_Bit <= r_RX_Bit + 1'b1;
      if (r_RX_State == STOP && w_RX_Tick && r_RX_Sync2) r_RX_Byte <= r_RX_Shift;
    end
  end

  assign io_Bus.o_RX_DV   = w_RX_DV;
  assign io_Bus.o_RX_Byte = r_RX_Byte;

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: direct RX frame table, TX/RX loopback sequences and random traffic.
module tb_uart_txrx;

  localparam int CPB = 217;

  logic clk = 1'b0;
  logic rst_n;
  logic r_loop;
  logic r_rx_drv;

  always #20 clk = ~clk;

  uart_txrx_if bus ();

`ifdef UART_LOOPBACK_EN
  assign bus.i_RX_Serial = r_loop ? 1'b0 : r_rx_drv;
  assign bus.i_Loopback  = r_loop;
`else
  assign bus.i_RX_Serial = r_loop ? bus.o_TX_Serial : r_rx_drv;
`endif

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .io_Bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_last;

  always @(negedge clk) if (bus.o_RX_DV === 1'b1) rx_q.push_back(bus.o_RX_Byte);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial frame bit k: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return 1'((b >> (k - 1)) & 8'h01);
  endfunction

  // mode 0: plain frame; 1: extra request (0x12) during data bit 3; 2: reset during data bit 3
  task automatic send_tx(input logic [7:0] b, input int mode);
    logic seen;
    bus.i_TX_Byte = b;
    bus.i_TX_DV   = 1'b1;
    tick();
    bus.i_TX_DV   = 1'b0;
    bus.i_TX_Byte = 8'($urandom);
    for (int n = 0; n < 10 * CPB; n++) begin
      int k, c;
      k = n / CPB;
      c = n % CPB;
      if (c == 0 || c == CPB - 1) begin
        check($sformatf("tx_line_%02h_bit%0d_c%0d", b, k, c), 32'(bus.o_TX_Serial), 32'(frame_bit(b, k)));
        check($sformatf("tx_active_done_%02h_bit%0d", b, k), 32'({bus.o_TX_Active, bus.o_TX_Done}), 32'h2);
      end
      if (mode == 1 && n == 4 * CPB + CPB / 2) begin
        bus.i_TX_Byte = 8'h12;
        bus.i_TX_DV   = 1'b1;
      end
      if (mode == 1 && n == 4 * CPB + CPB / 2 + 1) bus.i_TX_DV = 1'b0;
      if (mode == 2 && n == 4 * CPB + CPB / 2) begin
        rst_n = 1'b0;
        tick();
        check("rst_mid_tx_line_active_done", 32'({bus.o_TX_Serial, bus.o_TX_Active, bus.o_TX_Done}), 32'h4);
        check("rst_mid_rx_dv_byte", 32'({bus.o_RX_DV, bus.o_RX_Byte}), 32'h0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6 * CPB) begin
          tick();
          seen = seen | bus.o_TX_Done | bus.o_TX_Active;
        end
        check("rst_mid_no_done_no_active", 32'(seen), 32'h0);
        return;
      end
      tick();
    end
    check($sformatf("tx_done_pulse_%02h", b), 32'({bus.o_TX_Done, bus.o_TX_Active, bus.o_TX_Serial}), 32'h5);
    tick();
    check($sformatf("tx_after_done_%02h", b), 32'({bus.o_TX_Done, bus.o_TX_Active, bus.o_TX_Serial}), 32'h1);
  endtask

  task automatic expect_rx(input string name, input int exp_dvs, input logic [7:0] exp_byte);
    check({name, "_dv_count"}, 32'(rx_q.size()), 32'(exp_dvs));
    if (rx_q.size() > 0) check({name, "_dv_byte"}, 32'(rx_q.pop_front()), 32'(exp_byte));
    check({name, "_held_byte"}, 32'(bus.o_RX_Byte), 32'(rx_last));
    rx_q.delete();
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input logic glitch);
    if (glitch) begin
      r_rx_drv = 1'b0;
      repeat (CPB / 4) tick();
    end else begin
      for (int k = 0; k < 10; k++) begin
        r_rx_drv = (k == 9) ? stop : frame_bit(d, k);
        repeat (CPB) tick();
      end
    end
    r_rx_drv = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch;
    int         exp_dvs;
    logic [7:0] exp_byte;
  } rx_vec_t;

  initial begin
    rx_vec_t vecs[5];
    logic    seen;
    vecs[0] = '{data: 8'h00, stop: 1'b1, glitch: 1'b1, exp_dvs: 0, exp_byte: 8'h00};
    vecs[1] = '{data: 8'h3C, stop: 1'b1, glitch: 1'b0, exp_dvs: 1, exp_byte: 8'h3C};
    vecs[2] = '{data: 8'h55, stop: 1'b0, glitch: 1'b0, exp_dvs: 0, exp_byte: 8'h3C};
    vecs[3] = '{data: 8'hA5, stop: 1'b1, glitch: 1'b0, exp_dvs: 1, exp_byte: 8'hA5};
    vecs[4] = '{data: 8'h81, stop: 1'b0, glitch: 1'b0, exp_dvs: 0, exp_byte: 8'hA5};

    rst_n         = 1'b0;
    bus.i_TX_DV   = 1'b0;
    bus.i_TX_Byte = 8'h00;
    r_loop        = 1'b0;
    r_rx_drv      = 1'b1;
    rx_last       = 8'h00;
    repeat (3) tick();
    check("reset_tx_line_active_done", 32'({bus.o_TX_Serial, bus.o_TX_Active, bus.o_TX_Done}), 32'h4);
    check("reset_rx_dv_byte", 32'({bus.o_RX_DV, bus.o_RX_Byte}), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      rx_q.delete();
      rx_frame(vecs[i].data, vecs[i].stop, vecs[i].glitch);
      rx_last = vecs[i].exp_byte;
      expect_rx($sformatf("rx_vec%0d", i), vecs[i].exp_dvs, vecs[i].exp_byte);
    end

    r_loop = 1'b1;
    repeat (4) tick();
    rx_q.delete();

    send_tx(8'h4F, 0);
    rx_last = 8'h4F;
    expect_rx("loop_4F", 1, 8'h4F);

    send_tx(8'h00, 0);
    rx_last = 8'h00;
    expect_rx("b2b_00", 1, 8'h00);
    send_tx(8'hFF, 0);
    rx_last = 8'hFF;
    expect_rx("b2b_FF", 1, 8'hFF);
    send_tx(8'hA5, 0);
    rx_last = 8'hA5;
    expect_rx("b2b_A5", 1, 8'hA5);

    send_tx(8'h4F, 1);
    rx_last = 8'h4F;
    expect_rx("ignored_dv_4F", 1, 8'h4F);
    seen = 1'b0;
    repeat (3 * CPB) begin
      tick();
      seen = seen | bus.o_TX_Active | bus.o_TX_Done | ~bus.o_TX_Serial;
    end
    check("ignored_dv_no_second_frame", 32'(seen), 32'h0);
    check("ignored_dv_no_rx", 32'(rx_q.size()), 32'h0);

    send_tx(8'h66, 2);
    rx_last = 8'h00;
    expect_rx("reset_abort", 0, 8'h00);
    send_tx(8'h5A, 0);
    rx_last = 8'h5A;
    expect_rx("after_reset_5A", 1, 8'h5A);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_tx(d, 0);
      rx_last = d;
      expect_rx($sformatf("rand_loop%0d", i), 1, d);
    end

    r_loop = 1'b0;
    repeat (2 * CPB) tick();
    rx_q.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      logic       stop;
      int         dvs;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      dvs  = stop ? 1 : 0;
      if (stop) rx_last = d;
      rx_frame(d, stop, 1'b0);
      expect_rx($sformatf("rand_rx%0d", i), dvs, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
Full-duplex 8N1 UART transceiver: one byte-wide transmitter and one byte-wide receiver sharing a clock, reset and a compile-time baud divisor. Sits between byte-oriented logic (valid-pulse handshake) and the serial pins. TX and RX run independently. The RX path oversamples with the system clock and samples each bit at its centre.

Parameters:
CLKS_PER_BIT, 217, system clocks per serial bit (25 MHz / 115200 baud); legal range >= 4.

Ports:
i_Clock  input  1  system clock; all logic on rising edge.
i_Rst_n  input  1  synchronous, active-low reset.
i_TX_DV  input  1  one-cycle request to send i_TX_Byte.
i_TX_Byte  input  8  byte to transmit; sampled when i_TX_DV is accepted.
o_TX_Active  output  1  high while a frame (start through stop) is on the line.
o_TX_Serial  output  1  serial TX line; idles high.
o_TX_Done  output  1  one-cycle pulse at end of frame.
i_RX_Serial  input  1  serial RX line (asynchronous).
o_RX_DV  output  1  one-cycle pulse: o_RX_Byte holds a new byte.
o_RX_Byte  output  8  last received byte; held until the next good frame.

Behaviour:
- Reset: one clock domain; reset is synchronous and active-low. On a clock edge with i_Rst_n=0, both FSMs go to IDLE, counters clear, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_RX_DV=0, o_RX_Byte=0. Reset mid-frame aborts the frame; no Done/DV pulse is produced.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Every bit lasts exactly CLKS_PER_BIT clocks. Bit counter width is $clog2(CLKS_PER_BIT).
- TX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: line high. If i_TX_DV=1, latch i_TX_Byte and go to START; o_TX_Active rises on that same edge.
  - START drives 0, DATA drives bits 0..7, STOP drives 1; each for CLKS_PER_BIT clocks.
  - After STOP: o_TX_Done=1 and o_TX_Active=0 for one cycle (CLEANUP), then IDLE. A new i_TX_DV is accepted in the cycle after the Done pulse.
  - i_TX_DV outside IDLE is ignored; it is neither queued nor able to corrupt the frame in flight.
- RX input: i_RX_Serial passes through a 2-flop synchronizer. All RX decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: on synchronized 0, go to START.
  - START: after (CLKS_PER_BIT-1)/2 clocks, re-sample. If still 0, go to DATA; if 1, treat as a glitch and return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT clocks (bit centres) into bits 0..7, LSB first.
  - STOP: sample after CLKS_PER_BIT clocks. If 1, update o_RX_Byte and pulse o_RX_DV for exactly one cycle (CLEANUP). If 0 (framing error), discard the byte: no DV and o_RX_Byte unchanged.
  - After CLEANUP return to IDLE, ready for a back-to-back start bit.
- o_RX_DV latency is about 9.5 bit periods plus 2 sync clocks after the falling edge of the start bit.

Optional Feature:
UART_LOOPBACK_EN.
- Defined: adds input port i_Loopback (1 bit). When i_Loopback=1, the RX synchronizer input is (o_TX_Active ? o_TX_Serial : 1) and i_RX_Serial is ignored. o_TX_Serial still drives normally.
- Undefined: i_Loopback does not exist; RX always uses i_RX_Serial.

Decomposition:
- Package uart_pkg holds:
  - TX/RX state enum typedef (IDLE, START, DATA, STOP, CLEANUP);
  - DATA_BITS=8;
  - default CLKS_PER_BIT=217.
- One sub-module, uart_bit_timer: CLKS_PER_BIT-parameterised counter with clear/enable and a terminal pulse, instantiated once by TX and once by RX. FSMs stay in uart_txrx.

Test Plan:
- Loopback, CLKS_PER_BIT=217, 40 ns clock: i_TX_DV pulse with 0x4F -> o_RX_DV pulses once with o_RX_Byte=0x4F; o_TX_Done after 10*217 bit clocks plus CLEANUP.
- Bytes 0x00, 0xFF, 0xA5 sent back-to-back (each DV issued the cycle after o_TX_Done) -> three DV pulses with matching bytes; TX line shows the exact LSB-first bit pattern.
- i_TX_DV asserted mid-frame with 0x12 while sending 0x4F -> only 0x4F is transmitted; no second frame follows.
- RX low glitch of CLKS_PER_BIT/4 clocks -> no o_RX_DV; a subsequent valid 0x3C is received correctly.
- RX frame 0x55 with stop bit forced 0 -> no o_RX_DV and o_RX_Byte keeps its previous value.
- i_Rst_n low during data bit 3 of a TX frame -> next edge o_TX_Serial=1, o_TX_Active=0, no o_TX_Done; the next request transmits normally.
